// File: rtl/acia_loader.sv
// acia_loader: serial boot loader acting as bus master on the ACIA register port.
// Initialises the ACIA, receives a framed image (A5, addr, len, data, csum),
// writes it to program memory, answers ACK/NAK and releases the CPU reset.
//
// state  | meaning
// INIT0  | write ctrl 0x03 (ACIA master reset); skip to DONE if boot_en=0
// INIT1  | write ctrl 0x00 (interrupts off)
// POLL   | read status register
// STAT   | status visible: wait for rx full, remember the error bit
// RD     | read data register (clears rx full)
// CAP    | data byte visible: advance the frame parser
// TXPOLL | read status register before transmitting
// TXSTAT | status visible: wait for tx empty
// TXWR   | write ACK or NAK to the data register
// DONE   | bus idle, CPU released
module acia_loader #(
  parameter int          AW        = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_en,
  output logic          acia_cs,
  output logic          acia_we,
  output logic          acia_rs,
  output logic [7:0]    acia_din,
  input  logic [7:0]    acia_dout,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          done,
  output logic          nak,
  output logic          cpu_rst
);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_POLL, S_STAT, S_RD, S_CAP,
    S_TXPOLL, S_TXSTAT, S_TXWR, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    P_SYNC, P_ADDR_LO, P_ADDR_HI, P_LEN_LO, P_LEN_HI, P_DATA, P_CSUM
  } phase_t;

  state_t      state, state_nx;
  phase_t      phase;
  logic        st_err;
  logic        ack_q;
  logic [7:0]  addr_lo;
  logic [15:0] len_q;
  logic [7:0]  csum;
  logic [7:0]  din_q;
  logic        cs_c, we_c, rs_c;
  logic [7:0]  din_c;

  // Main state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT0;
    else     state <= state_nx;
  end

  // Next state and Moore decode of the ACIA bus strobes.
  always_comb begin
    state_nx = state;
    cs_c     = 1'b0;
    we_c     = 1'b0;
    rs_c     = 1'b0;
    din_c    = din_q;
    case (state)
      S_INIT0: begin
        cs_c = 1'b1; we_c = 1'b1; din_c = 8'h03;
        state_nx = boot_en ? S_INIT1 : S_DONE;
      end
      S_INIT1: begin
        cs_c = 1'b1; we_c = 1'b1; din_c = 8'h00;
        state_nx = S_POLL;
      end
      S_POLL: begin
        cs_c = 1'b1;
        state_nx = S_STAT;
      end
      S_STAT:   state_nx = acia_dout[0] ? S_RD : S_POLL;
      S_RD: begin
        cs_c = 1'b1; rs_c = 1'b1;
        state_nx = S_CAP;
      end
      S_CAP:    state_nx = (!st_err && phase == P_CSUM) ? S_TXPOLL : S_POLL;
      S_TXPOLL: begin
        cs_c = 1'b1;
        state_nx = S_TXSTAT;
      end
      S_TXSTAT: state_nx = acia_dout[1] ? S_TXWR : S_TXPOLL;
      S_TXWR: begin
        cs_c = 1'b1; we_c = 1'b1; rs_c = 1'b1;
        din_c = ack_q ? ACK_BYTE : NAK_BYTE;
        state_nx = ack_q ? S_DONE : S_POLL;
      end
      S_DONE:   state_nx = S_DONE;
      default:  state_nx = S_INIT0;
    endcase
  end

  // Bus is held idle while in reset; din keeps the last written value otherwise.
  assign acia_cs  = cs_c & ~rst;
  assign acia_we  = we_c & ~rst;
  assign acia_rs  = rs_c & ~rst;
  assign acia_din = rst ? 8'h00 : din_c;
  assign cpu_rst  = ~done;

  // Frame parser, memory write port, checksum and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= P_SYNC;
      st_err    <= 1'b0;
      ack_q     <= 1'b0;
      addr_lo   <= 8'h00;
      len_q     <= 16'h0000;
      csum      <= 8'h00;
      din_q     <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      nak       <= 1'b0;
    end else begin
      din_q  <= din_c;
      mem_we <= 1'b0;
      nak    <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + AW'(1);
      if (state == S_STAT) st_err <= acia_dout[4];
      if (state == S_INIT0 && !boot_en) done <= 1'b1;
      if (state == S_CAP) begin
        if (st_err) begin
          phase <= P_SYNC;
        end else begin
          case (phase)
            P_SYNC: begin
              if (acia_dout == SYNC_BYTE) begin
                phase <= P_ADDR_LO;
                csum  <= 8'h00;
              end
            end
            P_ADDR_LO: begin
              addr_lo <= acia_dout;
              phase   <= P_ADDR_HI;
            end
            P_ADDR_HI: begin
              mem_addr <= AW'({acia_dout, addr_lo});
              phase    <= P_LEN_LO;
            end
            P_LEN_LO: begin
              len_q[7:0] <= acia_dout;
              phase      <= P_LEN_HI;
            end
            P_LEN_HI: begin
              len_q[15:8] <= acia_dout;
              phase       <= ({acia_dout, len_q[7:0]} == 16'h0000) ? P_CSUM : P_DATA;
            end
            P_DATA: begin
              mem_we    <= 1'b1;
              mem_wdata <= acia_dout;
              csum      <= csum + acia_dout;
              len_q     <= len_q - 16'd1;
              if (len_q == 16'd1) phase <= P_CSUM;
            end
            P_CSUM:  ack_q <= (acia_dout == csum);
            default: phase <= P_SYNC;
          endcase
        end
      end
      if (state == S_TXWR) begin
        if (ack_q) begin
          done <= 1'b1;
        end else begin
          nak   <= 1'b1;
          phase <= P_SYNC;
        end
      end
    end
  end

endmodule

// File: tb/tb_acia_loader.sv
// Bench for acia_loader: behavioural ACIA on the register port, frames built from
// random and fixed contents, expected memory writes and replies derived from the frame.
module tb_acia_loader;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAKB = 8'h15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot_en = 1'b1;
  logic        acia_cs, acia_we, acia_rs;
  logic [7:0]  acia_din;
  logic [7:0]  acia_dout = 8'h00;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        done, nak, cpu_rst;

  always #5 clk = ~clk;

  acia_loader dut (
    .clk(clk), .rst(rst), .boot_en(boot_en),
    .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
    .acia_din(acia_din), .acia_dout(acia_dout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .nak(nak), .cpu_rst(cpu_rst)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ACIA model: rx byte queue ({err,byte}), status/data reads registered.
  logic [8:0]  rxq[$];
  logic        rx_full = 1'b0;
  logic        rx_err  = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  int          gap     = 10;
  int          tx_busy = 0;
  int          flush_req = 0;
  int          flush_ack = 0;

  always @(posedge clk) begin
    if (flush_req != flush_ack) begin
      rx_full   = 1'b0;
      rx_err    = 1'b0;
      gap       = 10;
      flush_ack = flush_req;
    end
    if (acia_cs && !acia_we) begin
      if (acia_rs) begin
        acia_dout <= rx_data;
        rx_full = 1'b0;
        rx_err  = 1'b0;
        gap     = $urandom_range(40, 10);
        tx_busy = $urandom_range(8, 0);
      end else begin
        acia_dout <= {3'b000, rx_err, 2'($urandom_range(3, 0)), (tx_busy == 0), rx_full};
      end
    end
    if (acia_cs && acia_we && acia_rs) tx_busy = $urandom_range(6, 0);
    else if (tx_busy > 0) tx_busy--;
    if (!rx_full) begin
      if (gap > 0) gap--;
      else if (rxq.size() > 0) begin
        {rx_err, rx_data} = rxq.pop_front();
        rx_full = 1'b1;
      end
    end
  end

  // Expected memory writes {addr,data} and expected transmitted replies.
  logic [23:0] expw[$];
  logic [7:0]  expt[$];
  int          wr_seen  = 0;
  logic        pend     = 1'b0;
  logic        pend_nak = 1'b0;

  // Monitor: transmitted replies, their follow-up flags, and memory writes.
  always @(negedge clk) begin
    logic [23:0] w;
    logic [7:0]  e;
    if (pend) begin
      if (pend_nak) begin
        chk("nak_pulse", nak, 1'b1);
        chk("nak_cpu_rst", cpu_rst, 1'b1);
      end else begin
        chk("ack_done", done, 1'b1);
        chk("ack_cpu_rst", cpu_rst, 1'b0);
      end
      pend = 1'b0;
    end else if (nak) begin
      chk("nak_spurious", nak, 1'b0);
    end
    if (!rst && acia_cs && acia_we && acia_rs) begin
      if (expt.size() == 0) chk("tx_unexpected", 32'(expt.size()), 1);
      else begin
        e = expt.pop_front();
        chk("tx_byte", acia_din, e);
      end
      pend     = 1'b1;
      pend_nak = (acia_din == NAKB);
    end
    if (mem_we === 1'b1) begin
      wr_seen++;
      if (expw.size() == 0) chk("wr_unexpected", 32'(expw.size()), 1);
      else begin
        w = expw.pop_front();
        chk("wr_addr", mem_addr, w[23:8]);
        chk("wr_data", mem_wdata, w[7:0]);
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic e = 1'b0);
    rxq.push_back({e, b});
  endtask

  task automatic send_frame(input logic [15:0] addr, input logic [7:0] d[$], input logic [7:0] cs);
    logic [7:0]  sum;
    logic [15:0] len;
    sum = 8'h00;
    len = 16'(d.size());
    push(SYNC); push(addr[7:0]); push(addr[15:8]); push(len[7:0]); push(len[15:8]);
    foreach (d[i]) begin
      push(d[i]);
      sum = sum + d[i];
      expw.push_back({addr + 16'(i), d[i]});
    end
    push(cs);
    expt.push_back((cs == sum) ? ACK : NAKB);
  endtask

  task automatic rand_frame(input int len, input bit corrupt);
    logic [7:0] d[$];
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      d.push_back(8'($urandom));
      sum = sum + d[i];
    end
    if (corrupt) sum = sum + 8'($urandom_range(255, 1));
    send_frame(16'($urandom), d, sum);
  endtask

  task automatic noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      push(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rxq.delete();
    expw.delete();
    expt.delete();
    flush_req++;
    @(negedge clk);
    chk("rst_cs", acia_cs, 1'b0);
    chk("rst_we", acia_we, 1'b0);
    chk("rst_rs", acia_rs, 1'b0);
    chk("rst_din", acia_din, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_nak", nak, 1'b0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    rst = 1'b0;
    #1;
    chk("init0_cs", acia_cs, 1'b1);
    chk("init0_we", acia_we, 1'b1);
    chk("init0_rs", acia_rs, 1'b0);
    chk("init0_din", acia_din, 8'h03);
    @(negedge clk);
    if (boot_en) begin
      chk("init1_cs", acia_cs, 1'b1);
      chk("init1_we", acia_we, 1'b1);
      chk("init1_din", acia_din, 8'h00);
      @(negedge clk);
      chk("poll_cs", acia_cs, 1'b1);
      chk("poll_we_rs", {acia_we, acia_rs}, 2'b00);
      @(negedge clk);
      chk("stat_cs", acia_cs, 1'b0);
      chk("stat_din_hold", acia_din, 8'h00);
      chk("init_cpu_rst", cpu_rst, 1'b1);
      chk("init_done", done, 1'b0);
    end else begin
      chk("skip_done", done, 1'b1);
      chk("skip_cpu_rst", cpu_rst, 1'b0);
      for (int i = 0; i < 6; i++) begin
        chk("skip_idle", {acia_cs, acia_we, acia_rs, mem_we}, 4'b0000);
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 8000 && !done; i++) @(negedge clk);
    chk(tag, done, 1'b1);
    chk("wr_left", 32'(expw.size()), 0);
    chk("tx_left", 32'(expt.size()), 0);
  endtask

  initial begin
    logic [7:0] d[$];
    int base;

    do_reset();
    d = '{8'h11, 8'h22, 8'h33};
    send_frame(16'h0100, d, 8'h66);
    wait_done("good_frame");

    do_reset();
    d = '{8'h44};
    send_frame(16'h0200, d, 8'h00);
    rand_frame(4, 1'b0);
    wait_done("nak_then_ack");

    do_reset();
    push(8'h00); push(8'hFF); push(8'h5A);
    d.delete();
    send_frame(16'h1234, d, 8'h00);
    wait_done("noise_len0");

    do_reset();
    d = '{8'hAA, 8'hBB};
    send_frame(16'hFFFF, d, 8'h65);
    wait_done("wrap");

    do_reset();
    push(SYNC); push(8'h00); push(8'h01, 1'b1);
    noise(2);
    rand_frame(3, 1'b0);
    wait_done("err_discard");

    do_reset();
    rand_frame(8, 1'b0);
    base = wr_seen;
    for (int i = 0; i < 4000 && wr_seen < base + 3; i++) @(negedge clk);
    chk("mid_data_reached", 32'(wr_seen >= base + 3), 1);
    do_reset();
    rand_frame(2, 1'b0);
    wait_done("after_mid_rst");

    for (int k = 0; k < 4; k++) begin
      do_reset();
      noise($urandom_range(3, 0));
      for (int j = $urandom_range(2, 0); j > 0; j--) rand_frame($urandom_range(5, 0), 1'b1);
      rand_frame($urandom_range(8, 1), 1'b0);
      wait_done("random_frames");
    end

    boot_en = 1'b0;
    do_reset();
    boot_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acia_loader.md
# acia_loader

Hardware serial boot loader: a bus master that drives the ACIA register port (cs/we/rs/din/dout) from the other side, in place of the CPU. After reset it initialises the ACIA and receives a framed binary image over the serial link. It writes the image into program memory through a byte write port, answers ACK or NAK, and then releases the CPU from reset. It sits between the ACIA, the boot RAM write mux and the CPU reset input.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker.
- ACK_BYTE, 8'h06, sent on good checksum.
- NAK_BYTE, 8'h15, sent on bad checksum.
- AW, 16, memory byte-address width (addr/len fields are 16 bits, truncated to AW).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- boot_en  in  1  sampled in INIT0; 0 = skip loading and go straight to DONE.
- acia_cs  out  1  ACIA chip select.
- acia_we  out  1  ACIA write enable.
- acia_rs  out  1  ACIA register select: 0 = control/status, 1 = data.
- acia_din  out  8  write data to ACIA.
- acia_dout  in  8  ACIA read data, registered by the ACIA, valid the cycle after a read strobe.
- mem_we  out  1  one-cycle byte write strobe.
- mem_addr  out  AW  byte address.
- mem_wdata  out  8  byte data.
- done  out  1  load complete (sticky until rst).
- nak  out  1  one-cycle pulse when NAK is transmitted.
- cpu_rst  out  1  CPU reset, high until done.

## Operation
- The ACIA bus outputs are Moore decodes of the state. Every access is a single-cycle strobe. Outside strobe states cs=we=rs=0 and din holds.
- Main FSM:
  - INIT0: write ctrl 0x03 (ACIA master reset). If boot_en=0, go to DONE instead.
  - INIT1: write ctrl 0x00 (IRQs off). Go to POLL.
  - POLL: read status (cs=1, rs=0, we=0).
  - STAT: examine acia_dout. If bit0=0, go to POLL; otherwise go to RD.
  - RD: read data (cs=1, rs=1, we=0). This clears the ACIA rx-full flag.
  - CAP: capture the byte and latch status bit4 from STAT as err.
    - If err=1: discard the byte and reset the parser to SYNC.
    - Otherwise: advance the parser.
  - TXPOLL: read status.
  - TXSTAT: if bit1 (tx empty)=1, go to TXWR; otherwise go to TXPOLL.
  - TXWR: write data register with ACK_BYTE or NAK_BYTE (cs=1, rs=1, we=1).
    - After ACK, go to DONE.
    - After NAK, pulse nak, set parser to SYNC and go to POLL.
  - DONE: bus idle forever, done=1, cpu_rst=0.
- Parser phases, advanced in CAP:
  - SYNC: a byte equal to SYNC_BYTE moves to ADDR_LO. Any other byte is ignored.
  - ADDR_LO, ADDR_HI: 16-bit little-endian start address.
  - LEN_LO, LEN_HI: 16-bit little-endian byte count.
    - After LEN_HI, go to DATA, or to CSUM if len=0.
  - DATA: each byte is written to memory, csum += byte (mod 256), len decrements. At len=0, go to CSUM.
  - CSUM: if the received byte equals csum, ACK; otherwise NAK. Either way go to TXPOLL.
- csum clears on entry to ADDR_LO. mem_addr loads from the address field and increments by 1 modulo 2^AW after each write. Wrap is silent.
- Every byte received in CAP outside CSUM returns to POLL.

## Timing
- Reset values:
  - acia_cs=0, acia_we=0, acia_rs=0, acia_din=0
  - mem_we=0, mem_addr=0, mem_wdata=0
  - done=0, nak=0, cpu_rst=1
  - state INIT0, parser SYNC, csum=0
- Init takes 2 cycles: the INIT0 write is in cycle 1 after rst falls, INIT1 in cycle 2.
- Polling takes 2 cycles per status read. A received byte costs 4 cycles from the status strobe to CAP.
- mem_we is high for exactly the one cycle after a DATA-phase CAP, with mem_addr and mem_wdata valid in that cycle. mem_addr increments in the following cycle.
- Byte spacing at 115200 baud (≥208 clk) always exceeds the loop time, so no overrun handling is needed beyond err.
- nak is high in the cycle after TXWR(NAK).
- done rises and cpu_rst falls in the cycle after TXWR(ACK), or the cycle after INIT0 when boot_en=0.
- rst mid-frame: return to INIT0 immediately, the partial image is abandoned, cpu_rst=1. Memory already written is not restored.

## Test plan
- Reset/init: after rst falls, observe a ctrl write of 0x03 then 0x00 on consecutive cycles, then alternating status reads. cpu_rst=1, done=0.
- Good frame A5 00 01 03 00 11 22 33 66:
  - Memory writes 0x0100=11, 0x0101=22, 0x0102=33.
  - 0x06 written to the ACIA data register.
  - done=1, cpu_rst=0.
- Bad checksum A5 00 02 01 00 44 00:
  - One write of 0x0200=44.
  - 0x15 sent and the nak pulse seen, cpu_rst stays 1.
  - A following good frame is ACKed.
- Noise 00 FF 5A before A5, then a len=0 frame with csum 00: no memory writes, ACK sent, done=1.
- Wrap: A5 FF FF 02 00 AA BB 65 gives writes FFFF=AA then 0000=BB, then ACK.
- Status bit4 set on the 3rd byte: byte discarded, parser back to SYNC, no write. Also assert rst mid-DATA: immediate INIT0 re-entry, cpu_rst=1.
